sram_ctrl: RTL and testbench

- MEM-stage load/store engine for the board's external 16-bit asynchronous SRAM; generates the `sram_stall` consumed by the hazard unit, which freezes every pipeline register while a memory access is in flight.
- Splits each 32-bit access into up to two 16-bit halfword phases with programmable wait states.
- Returns load data to the MEM/WB path in the cycle the stall drops.

---
 rtl/sram_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl -- MEM-stage load/store engine for a 16-bit asynchronous SRAM.
//
// Each 32-bit access becomes at most two halfword phases: LO for bytes 1:0
// and HI for bytes 3:2. Each phase lasts WAIT_CYCLES cycles. A half whose
// byte enables are all clear is skipped. o_sram_stall freezes the pipeline
// until the DONE cycle. Load data is valid in o_rdata during DONE and is
// held afterwards.
//
// Parameters:
//   WAIT_CYCLES  cycles per halfword phase (>= 2)
//   ADDR_W       SRAM halfword address width
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req                   LSU access pending; held stable while stalled
//   i_wren                  1 = store, 0 = load
//   i_addr                  byte address; bits [ADDR_W:2] select the word
//   i_wdata, i_bmask        lane-aligned store data and byte enables
//   o_rdata                 load data (valid in DONE, then held)
//   o_sram_stall            stall request to the hazard unit
//   o_SRAM_ADDR             SRAM halfword address
//   io_SRAM_DQ              SRAM data bus
//   o_SRAM_*_N              active-low SRAM strobes
//   o_stall_cnt             stalled-cycle counter (only with SRAM_CTRL_PERF_EN)
//
// Optional build macro:
//   SRAM_CTRL_PERF_EN       adds the 32-bit o_stall_cnt performance counter
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_wren,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_bmask,
  output logic [31:0]       o_rdata,
  output logic              o_sram_stall,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
`ifdef SRAM_CTRL_PERF_EN
  ,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // Request captured in IDLE. Only the word-select address bits are kept.
  logic              wren_reg;
  logic [ADDR_W-2:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        bmask_reg;

  logic              capture;
  logic              phase_active;
  logic              half_hi;
  logic              last_cycle;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic [15:0]       rd_half;
  logic [1:0]        half_mask;

  // Address bits outside the word select are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};

  assign capture      = (state_reg == IDLE) && i_req;
  assign phase_active = (state_reg == LO) || (state_reg == HI);
  assign half_hi      = (state_reg == HI);
  assign last_cycle   = (cnt_reg == CNT_LAST);
  assign half_mask    = half_hi ? bmask_reg[3:2] : bmask_reg[1:0];

  // The stall is combinational so the pipeline freezes in the same cycle
  // the request first appears in IDLE.
  assign o_sram_stall = i_req && (state_reg != DONE);

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_req) begin
          cnt_next = '0;
          if (|i_bmask[1:0])      state_next = LO;
          else if (|i_bmask[3:2]) state_next = HI;
          else                    state_next = DONE;
        end
      end
      LO: begin
        if (last_cycle) begin
          cnt_next   = '0;
          state_next = (|bmask_reg[3:2]) ? HI : DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HI: begin
        if (last_cycle) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        // The request is not re-sampled here. The pipeline advances on this
        // edge and the next instruction's request is seen back in IDLE.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wren_reg  <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      bmask_reg <= '0;
    end else if (capture) begin
      wren_reg  <= i_wren;
      waddr_reg <= i_addr[ADDR_W:2];
      wdata_reg <= i_wdata;
      bmask_reg <= i_bmask;
    end
  end

  // Disabled byte lanes of a sampled half read back as zero.
  assign rd_half = {half_mask[1] ? io_SRAM_DQ[15:8] : 8'h00,
                    half_mask[0] ? io_SRAM_DQ[7:0]  : 8'h00};

  // A new load clears the result, so a skipped half also reads as zero.
  // Each half is sampled on the last cycle of its phase, when the SRAM
  // output has had the full wait time to settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (capture && !i_wren) begin
      o_rdata <= '0;
    end else if (phase_active && !wren_reg && last_cycle) begin
      if (half_hi) o_rdata[31:16] <= rd_half;
      else         o_rdata[15:0]  <= rd_half;
    end
  end

  // Strobes and bus control are decoded only from registers, so they stay
  // clean while the request inputs are changing. When reset asserts, the
  // state clears asynchronously and the strobes release at once.
  always_comb begin
    o_SRAM_CE_N = 1'b1;
    o_SRAM_OE_N = 1'b1;
    o_SRAM_WE_N = 1'b1;
    o_SRAM_LB_N = 1'b1;
    o_SRAM_UB_N = 1'b1;
    o_SRAM_ADDR = '0;
    dq_oe       = 1'b0;
    dq_out      = half_hi ? wdata_reg[31:16] : wdata_reg[15:0];
    if (phase_active) begin
      o_SRAM_CE_N = 1'b0;
      o_SRAM_ADDR = {waddr_reg, half_hi};
      o_SRAM_LB_N = ~half_mask[0];
      o_SRAM_UB_N = ~half_mask[1];
      if (wren_reg) begin
        // WE_N rises one cycle before the phase ends. The data stays driven
        // through that cycle, which gives the SRAM its data hold time.
        o_SRAM_WE_N = last_cycle;
        dq_oe       = 1'b1;
      end else begin
        o_SRAM_OE_N = 1'b0;
      end
    end
  end

  assign io_SRAM_DQ = dq_oe ? dq_out : 16'bz;

`ifdef SRAM_CTRL_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          o_stall_cnt <= '0;
    else if (o_sram_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- directed, self-checking bench for sram_ctrl.
// A behavioural 16-bit SRAM sits on the DQ bus. Expected load data is queued
// when a load is issued and compared when the DONE cycle is observed.
module tb_sram_ctrl;
  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_W      = 18;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic              wren;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [3:0]        bmask;
  logic [31:0]       rdata;
  logic              stall;
  logic [ADDR_W-1:0] sram_addr;
  wire  [15:0]       dq;
  logic              ce_n, oe_n, we_n, lb_n, ub_n;
`ifdef SRAM_CTRL_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_wren       (wren),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_bmask      (bmask),
    .o_rdata      (rdata),
    .o_sram_stall (stall),
    .o_SRAM_ADDR  (sram_addr),
    .io_SRAM_DQ   (dq),
    .o_SRAM_CE_N  (ce_n),
    .o_SRAM_OE_N  (oe_n),
    .o_SRAM_WE_N  (we_n),
    .o_SRAM_LB_N  (lb_n),
    .o_SRAM_UB_N  (ub_n)
`ifdef SRAM_CTRL_PERF_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  // Behavioural SRAM: halfword i preloads to 16'hA500 | i, and byte writes
  // honour LB_N/UB_N.
  logic [15:0] mem [0:255];
  logic        sram_oe;
  assign sram_oe = !ce_n && !oe_n && we_n;
  assign dq = sram_oe ? mem[sram_addr[7:0]] : 16'bz;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= dq[15:8];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  // Observations gathered over one access.
  int          n_stall, n_oe, n_ce, n_we;
  logic        first_stall, done_stall, done_seen, lo_seen, hi_seen;
  logic [1:0]  lo_we, hi_we;
  logic [15:0] lo_dq, hi_dq;
  logic [31:0] lo_addr, hi_addr;
  logic        lo_lb, lo_ub, hi_lb, hi_ub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] bm);
    @(posedge clk);
    #1;
    req = 1'b1; wren = wr; addr = a; wdata = wd; bmask = bm;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Samples at each falling edge, starting with the cycle in progress, until
  // the stall drops (DONE). Loads are scored against the expected queue.
  task automatic observe();
    n_stall = 0; n_oe = 0; n_ce = 0; n_we = 0;
    first_stall = 1'b0; done_stall = 1'b1; done_seen = 1'b0;
    lo_seen = 1'b0; hi_seen = 1'b0; lo_we = 2'b11; hi_we = 2'b11;
    lo_dq = '0; hi_dq = '0; lo_addr = '1; hi_addr = '1;
    lo_lb = 1'b1; lo_ub = 1'b1; hi_lb = 1'b1; hi_ub = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) first_stall = stall;
      if (!ce_n) begin
        n_ce++;
        if (!we_n) n_we++;
        if (!sram_addr[0]) begin
          lo_seen = 1'b1; lo_addr = 32'(sram_addr); lo_we = {lo_we[0], we_n};
          lo_lb = lb_n; lo_ub = ub_n;
          if (!we_n) lo_dq = dq;
        end else begin
          hi_seen = 1'b1; hi_addr = 32'(sram_addr); hi_we = {hi_we[0], we_n};
          hi_lb = lb_n; hi_ub = ub_n;
          if (!we_n) hi_dq = dq;
        end
      end
      if (!oe_n) n_oe++;
      if (stall) begin
        n_stall++;
      end else begin
        done_seen  = 1'b1;
        done_stall = stall;
        if (!wren) begin
          if (exp_q.size() == 0) chk("scoreboard_empty", 32'(exp_q.size()), 1);
          else chk("rdata", rdata, exp_q.pop_front());
        end
        break;
      end
    end
    chk("done_reached", {31'b0, done_seen}, 1);
    $display("txn %s addr=0x%08h bmask=0x%0h stall_cycles=%0d rdata=0x%08h",
             wren ? "store" : "load ", addr, bmask, n_stall, rdata);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; wren = 1'b0; addr = '0; wdata = '0; bmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_strobes", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_rdata", rdata, 0);
`ifdef SRAM_CTRL_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Back-to-back word loads from the preloaded SRAM.
    exp_q.push_back(32'hA511A510);
    drive(1'b0, 32'h20, 32'h0, 4'hF);
    observe();
    chk("b2b1_stall", 32'(n_stall), 5);
    chk("b2b1_oe", 32'(n_oe), 4);
    exp_q.push_back(32'hA513A512);
    drive(1'b0, 32'h24, 32'h0, 4'hF);
    observe();
    chk("b2b2_first_stall", {31'b0, first_stall}, 1);
    chk("b2b2_stall", 32'(n_stall), 5);
    chk("b2b2_we", 32'(n_we), 0);
`ifdef SRAM_CTRL_PERF_EN
    chk("b2b_stall_cnt", stall_cnt, 10);
`endif
    idle(1);

    // Full-word store.
    drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    observe();
    chk("sw_stall", 32'(n_stall), 5);
    chk("sw_done_stall", {31'b0, done_stall}, 0);
    chk("sw_lo_addr", lo_addr, 32'h8);
    chk("sw_hi_addr", hi_addr, 32'h9);
    chk("sw_lo_dq", 32'(lo_dq), 32'hBEEF);
    chk("sw_hi_dq", 32'(hi_dq), 32'hDEAD);
    chk("sw_lo_we", 32'(lo_we), 32'h1);
    chk("sw_hi_we", 32'(hi_we), 32'h1);
    chk("sw_lanes", {28'b0, lo_lb, lo_ub, hi_lb, hi_ub}, 0);
    chk("sw_oe", 32'(n_oe), 0);

    // Read the word back.
    exp_q.push_back(32'hDEADBEEF);
    drive(1'b0, 32'h10, 32'h0, 4'hF);
    observe();
    chk("lw_stall", 32'(n_stall), 5);
    chk("lw_oe", 32'(n_oe), 4);
    idle(2);

    // Single-byte store into byte 2: LO skipped.
    drive(1'b1, 32'h12, 32'h00AB0000, 4'h4);
    observe();
    chk("sb_stall", 32'(n_stall), 3);
    chk("sb_lo_seen", {31'b0, lo_seen}, 0);
    chk("sb_hi_addr", hi_addr, 32'h9);
    chk("sb_hi_lanes", {30'b0, hi_lb, hi_ub}, 32'h1);
    chk("sb_hi_dq", 32'(hi_dq), 32'h00AB);

    exp_q.push_back(32'hDEABBEEF);
    drive(1'b0, 32'h10, 32'h0, 4'hF);
    observe();
    chk("lb_stall", 32'(n_stall), 5);

    // Degenerate request: no enabled bytes.
    drive(1'b1, 32'h40, 32'h12345678, 4'h0);
    observe();
    chk("deg_stall", 32'(n_stall), 1);
    chk("deg_ce", 32'(n_ce), 0);

    // Reset during the second HI cycle of a store.
    drive(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    repeat (4) @(posedge clk);
    #2;
    chk("mid_pre_addr", 32'(sram_addr), 32'h19);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'b0, ce_n, we_n}, 32'h3);
    chk("mid_rst_addr", 32'(sram_addr), 0);
    chk("mid_rst_rdata", rdata, 0);
    #1 rst_n = 1'b1;
    observe();
    chk("mid_fresh_stall", 32'(n_stall), 5);
    idle(1);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
